// File: rtl/window_feed_if.sv
// Bundles the window_feed stream, coefficient-write and multiplier-feed signals.
// master = stimulus/host side, slave = window_feed.
interface window_feed_if #(
    parameter int WIDTH = 16,
    parameter int LOG_N = 6
);
    logic             enable;
    logic             di_en;
    logic [WIDTH-1:0] di_re;
    logic             restart;
    logic             coef_we;
    logic [LOG_N-1:0] coef_addr;
    logic [WIDTH-1:0] coef_data;
    logic [WIDTH-1:0] a_re;
    logic [WIDTH-1:0] b_re;
    logic             do_en;
    logic             do_first;
    logic             do_last;
    logic [15:0]      frame_cnt;

    modport master (
        output enable, di_en, di_re, restart, coef_we, coef_addr, coef_data,
        input  a_re, b_re, do_en, do_first, do_last, frame_cnt
    );

    modport slave (
        input  enable, di_en, di_re, restart, coef_we, coef_addr, coef_data,
        output a_re, b_re, do_en, do_first, do_last, frame_cnt
    );
endinterface

// File: rtl/window_feed.sv
// Pairs each frame sample with its window coefficient for a downstream multiplier.
// Latency: 2 cycles from accepted sample to do_en. No backpressure: di_en is always taken in RUN/DRAIN.
// Optional coefficient RAM with write port: WINDOW_FEED_COEF_WR_EN (otherwise rectangular window).
module window_feed #(
    parameter int WIDTH = 16,
    parameter int LOG_N = 6
) (
    input  logic          clock,
    input  logic          reset_n,
    window_feed_if.slave  bus
);
    localparam int N = 1 << LOG_N;
    localparam logic [LOG_N-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           r_state, w_state_nxt;
    logic [LOG_N-1:0] r_idx, w_idx_nxt, w_sidx;
    logic             w_acc;
    logic [15:0]      r_frame_cnt;

    logic             r_s1_vld, r_s1_first, r_s1_last;
    logic [WIDTH-1:0] r_s1_dat;
    logic [WIDTH-1:0] w_s1_coef;

    logic             r_do_en, r_do_first, r_do_last;
    logic [WIDTH-1:0] r_a_re, r_b_re;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // The exit decision uses the index after this cycle's acceptance, so a
    // frame that just wrapped (or was restarted) ends cleanly on index 0.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_acc       = 1'b0;
        w_sidx      = bus.restart ? '0 : r_idx;
        case (r_state)
            IDLE: begin
                w_idx_nxt = '0;
                if (bus.enable) w_state_nxt = RUN;
            end
            RUN, DRAIN: begin
                w_acc = bus.di_en;
                if (bus.di_en)        w_idx_nxt = w_sidx + 1'b1;
                else if (bus.restart) w_idx_nxt = '0;
                if (bus.enable)            w_state_nxt = RUN;
                else if (w_idx_nxt == '0) w_state_nxt = IDLE;
                else                       w_state_nxt = DRAIN;
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_cnt <= '0;
        end else if (w_acc && (w_sidx == LAST_IDX)) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_vld   <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_dat   <= '0;
        end else begin
            r_s1_vld <= w_acc;
            if (w_acc) begin
                r_s1_dat   <= bus.di_re;
                r_s1_first <= (w_sidx == '0);
                r_s1_last  <= (w_sidx == LAST_IDX);
            end
        end
    end

`ifdef WINDOW_FEED_COEF_WR_EN
    logic [WIDTH-1:0] r_mem [N];
    logic [WIDTH-1:0] r_s1_coef;

    // No reset: coefficients survive reset_n.
    always_ff @(posedge clock) begin
        if (bus.coef_we) r_mem[bus.coef_addr] <= bus.coef_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_coef <= '0;
        end else if (w_acc) begin
            r_s1_coef <= r_mem[w_sidx];
        end
    end

    assign w_s1_coef = r_s1_coef;
`else
    logic w_unused_coef;

    assign w_unused_coef = ^{bus.coef_we, bus.coef_addr, bus.coef_data};
    assign w_s1_coef     = {1'b0, {(WIDTH-1){1'b1}}};
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_do_en    <= 1'b0;
            r_do_first <= 1'b0;
            r_do_last  <= 1'b0;
            r_a_re     <= '0;
            r_b_re     <= '0;
        end else begin
            r_do_en    <= r_s1_vld;
            r_do_first <= r_s1_vld & r_s1_first;
            r_do_last  <= r_s1_vld & r_s1_last;
            if (r_s1_vld) begin
                r_a_re <= r_s1_dat;
                r_b_re <= w_s1_coef;
            end
        end
    end

    assign bus.a_re      = r_a_re;
    assign bus.b_re      = r_b_re;
    assign bus.do_en     = r_do_en;
    assign bus.do_first  = r_do_first;
    assign bus.do_last   = r_do_last;
    assign bus.frame_cnt = r_frame_cnt;
endmodule

// File: tb/tb_window_feed.sv
// Self-checking bench for window_feed: cycle vector table, directed frame scenarios and
// random traffic against a queue-based reference of expected sample/coefficient pairs.
module tb_window_feed;
    localparam int WIDTH = 16;
    localparam int LOG_N = 6;
    localparam int N     = 64;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    window_feed_if #(.WIDTH(WIDTH), .LOG_N(LOG_N)) bus ();

    window_feed #(.WIDTH(WIDTH), .LOG_N(LOG_N)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          due;
        logic [15:0] a;
        logic [15:0] b;
        logic        first;
        logic        last;
    } pair_t;

    typedef struct {
        logic        en;
        logic        dv;
        logic [15:0] d;
        logic        rs;
        logic        x_en;
        logic        x_first;
        logic        x_last;
        logic [15:0] x_a;
    } vec_t;

    pair_t       q[$];
    int          checks = 0;
    int          errors = 0;
    int          edges  = 0;
    int          pairs_seen = 0;
    int          m_mode = 0;     // 0 idle, 1 run, 2 drain
    int          m_idx = 0;
    int          m_frames = 0;
    logic [15:0] last_a = '0;
    logic [15:0] last_b = '0;
`ifdef WINDOW_FEED_COEF_WR_EN
    logic [15:0] m_coef [N];
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edges);
        end
    endtask

    function automatic logic [15:0] coef_of(input int k);
`ifdef WINDOW_FEED_COEF_WR_EN
        return m_coef[k];
`else
        return (k >= 0) ? 16'h7FFF : 16'h7FFF;
`endif
    endfunction

    task automatic model(input logic en, input logic dv, input logic [15:0] d, input logic rs,
                         input logic cwe, input logic [5:0] ca, input logic [15:0] cd);
        int k;
        if (m_mode == 0) begin
            m_idx = 0;
            if (en) m_mode = 1;
        end else begin
            if (dv) begin
                k = rs ? 0 : m_idx;
                q.push_back('{due: edges + 1, a: d, b: coef_of(k), first: (k == 0), last: (k == N-1)});
                if (k == N-1) m_frames = (m_frames + 1) % 65536;
                m_idx = (k + 1) % N;
            end else if (rs) begin
                m_idx = 0;
            end
            m_mode = en ? 1 : ((m_idx == 0) ? 0 : 2);
        end
`ifdef WINDOW_FEED_COEF_WR_EN
        if (cwe) m_coef[ca] = cd;
`else
        if (cwe && (ca > 6'd63) && (cd == 16'h0)) m_mode = m_mode;
`endif
    endtask

    task automatic check_cycle();
        pair_t p;
        if (bus.do_en) pairs_seen++;
        if (q.size() > 0 && q[0].due == edges) begin
            p = q.pop_front();
            chk("pair_do_en", {31'd0, bus.do_en}, 32'd1);
            chk("pair_a_re", {16'd0, bus.a_re}, {16'd0, p.a});
            chk("pair_b_re", {16'd0, bus.b_re}, {16'd0, p.b});
            chk("pair_first", {31'd0, bus.do_first}, {31'd0, p.first});
            chk("pair_last", {31'd0, bus.do_last}, {31'd0, p.last});
            last_a = p.a;
            last_b = p.b;
        end else begin
            chk("idle_do_en", {31'd0, bus.do_en}, 32'd0);
            chk("idle_first", {31'd0, bus.do_first}, 32'd0);
            chk("idle_last", {31'd0, bus.do_last}, 32'd0);
            chk("hold_a_re", {16'd0, bus.a_re}, {16'd0, last_a});
            chk("hold_b_re", {16'd0, bus.b_re}, {16'd0, last_b});
        end
        chk("frame_cnt", {16'd0, bus.frame_cnt}, m_frames);
    endtask

    task automatic step(input logic en, input logic dv, input logic [15:0] d, input logic rs,
                        input logic cwe = 1'b0, input logic [5:0] ca = '0, input logic [15:0] cd = '0);
        bus.enable    = en;
        bus.di_en     = dv;
        bus.di_re     = d;
        bus.restart   = rs;
        bus.coef_we   = cwe;
        bus.coef_addr = ca;
        bus.coef_data = cd;
        @(posedge clock);
        edges++;
        model(en, dv, d, rs, cwe, ca, cd);
        @(negedge clock);
        check_cycle();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_do_en"}, {31'd0, bus.do_en}, 32'd0);
        chk({tag, "_first"}, {31'd0, bus.do_first}, 32'd0);
        chk({tag, "_last"}, {31'd0, bus.do_last}, 32'd0);
        chk({tag, "_a_re"}, {16'd0, bus.a_re}, 32'd0);
        chk({tag, "_b_re"}, {16'd0, bus.b_re}, 32'd0);
        chk({tag, "_frame"}, {16'd0, bus.frame_cnt}, 32'd0);
    endtask

    task automatic reset_pulse();
        #2 reset_n = 1'b0;
        #1 check_zero("rst_async");
        q.delete();
        m_mode = 0; m_idx = 0; m_frames = 0; last_a = '0; last_b = '0;
        bus.enable = 1'b1;
        bus.di_en  = 1'b1;
        bus.di_re  = 16'h5A5A;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_zero("rst_hold");
        bus.enable = 1'b0;
        bus.di_en  = 1'b0;
        reset_n    = 1'b1;
    endtask

    task automatic frame_run(input bit gaps);
        step(1'b1, 1'b0, 16'h0, 1'b0);
        for (int k = 0; k < N; k++) begin
            if (gaps) repeat ($urandom_range(0, 3)) step(1'b1, 1'b0, 16'($urandom), 1'b0);
            step(1'b1, 1'b1, 16'(k), 1'b0);
        end
        repeat (3) step(1'b1, 1'b0, 16'h0, 1'b0);
    endtask

    vec_t tbl[9];
    int   base;

    initial begin
        tbl[0] = '{en:1'b0, dv:1'b1, d:16'h11, rs:1'b0, x_en:1'b0, x_first:1'b0, x_last:1'b0, x_a:16'h00};
        tbl[1] = '{en:1'b1, dv:1'b1, d:16'h22, rs:1'b0, x_en:1'b0, x_first:1'b0, x_last:1'b0, x_a:16'h00};
        tbl[2] = '{en:1'b1, dv:1'b1, d:16'h33, rs:1'b0, x_en:1'b0, x_first:1'b0, x_last:1'b0, x_a:16'h00};
        tbl[3] = '{en:1'b1, dv:1'b0, d:16'h44, rs:1'b0, x_en:1'b1, x_first:1'b1, x_last:1'b0, x_a:16'h33};
        tbl[4] = '{en:1'b1, dv:1'b1, d:16'h55, rs:1'b0, x_en:1'b0, x_first:1'b0, x_last:1'b0, x_a:16'h33};
        tbl[5] = '{en:1'b1, dv:1'b1, d:16'h66, rs:1'b0, x_en:1'b1, x_first:1'b0, x_last:1'b0, x_a:16'h55};
        tbl[6] = '{en:1'b0, dv:1'b1, d:16'h77, rs:1'b1, x_en:1'b1, x_first:1'b0, x_last:1'b0, x_a:16'h66};
        tbl[7] = '{en:1'b0, dv:1'b0, d:16'h00, rs:1'b0, x_en:1'b1, x_first:1'b1, x_last:1'b0, x_a:16'h77};
        tbl[8] = '{en:1'b0, dv:1'b0, d:16'h00, rs:1'b0, x_en:1'b0, x_first:1'b0, x_last:1'b0, x_a:16'h77};

        bus.enable = 1'b0; bus.di_en = 1'b0; bus.di_re = '0; bus.restart = 1'b0;
        bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_zero("reset");
        reset_n = 1'b1;

        // Load the window while idle; without the RAM these writes must be ignored.
        for (int k = 0; k < N; k++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 6'(k), 16'(k + 16'h100));

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].en, tbl[i].dv, tbl[i].d, tbl[i].rs);
            chk("tbl_do_en", {31'd0, bus.do_en}, {31'd0, tbl[i].x_en});
            chk("tbl_first", {31'd0, bus.do_first}, {31'd0, tbl[i].x_first});
            chk("tbl_last", {31'd0, bus.do_last}, {31'd0, tbl[i].x_last});
            chk("tbl_a_re", {16'd0, bus.a_re}, {16'd0, tbl[i].x_a});
        end

        // Full frame, back to back.
        reset_pulse();
        base = pairs_seen;
        frame_run(1'b0);
        chk("full_pairs", pairs_seen - base, 64);
        chk("full_frames", {16'd0, bus.frame_cnt}, 32'd1);

        // Same frame with random gaps.
        reset_pulse();
        base = pairs_seen;
        frame_run(1'b1);
        chk("gap_pairs", pairs_seen - base, 64);
        chk("gap_frames", {16'd0, bus.frame_cnt}, 32'd1);

        // Enable dropped after 10 samples: the frame drains, then input is ignored.
        reset_pulse();
        base = pairs_seen;
        step(1'b1, 1'b0, 16'h0, 1'b0);
        for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 16'(k), 1'b0);
        for (int k = 10; k < N; k++) begin
            repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 16'h0, 1'b0);
            step(1'b0, 1'b1, 16'(k), 1'b0);
        end
        repeat (3) step(1'b0, 1'b0, 16'h0, 1'b0);
        chk("drain_pairs", pairs_seen - base, 64);
        repeat (5) step(1'b0, 1'b1, 16'hDEAD, 1'b0);
        chk("after_drain_pairs", pairs_seen - base, 64);
        chk("drain_frames", {16'd0, bus.frame_cnt}, 32'd1);

        // Restart on sample 20: it becomes index 0 and the partial frame is not counted.
        reset_pulse();
        step(1'b1, 1'b0, 16'h0, 1'b0);
        for (int k = 0; k < 20; k++) step(1'b1, 1'b1, 16'(k), 1'b0);
        step(1'b1, 1'b1, 16'h0020, 1'b1);
        for (int k = 1; k < N-1; k++) step(1'b1, 1'b1, 16'(k + 16'h40), 1'b0);
        repeat (3) step(1'b1, 1'b0, 16'h0, 1'b0);
        chk("restart_frame_hold", {16'd0, bus.frame_cnt}, 32'd0);
        step(1'b1, 1'b1, 16'h7F7F, 1'b0);
        repeat (3) step(1'b1, 1'b0, 16'h0, 1'b0);
        chk("restart_frame_done", {16'd0, bus.frame_cnt}, 32'd1);

        // Reset with samples in flight, then coefficients still usable.
        step(1'b1, 1'b1, 16'hAAAA, 1'b0);
        step(1'b1, 1'b1, 16'hBBBB, 1'b0);
        reset_pulse();
        base = pairs_seen;
        repeat (4) step(1'b0, 1'b1, 16'h1234, 1'b0);
        chk("post_reset_quiet", pairs_seen - base, 0);
        step(1'b1, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b1, 16'h8001, 1'b0);
        step(1'b1, 1'b1, 16'hFFFF, 1'b0);
        repeat (3) step(1'b1, 1'b0, 16'h0, 1'b0);
        chk("post_reset_pairs", pairs_seen - base, 2);

        // Random traffic: enable drops, gaps, restarts and coefficient rewrites.
        reset_pulse();
        for (int i = 0; i < 2500; i++) begin
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 2) != 0), 16'($urandom),
                 ($urandom_range(0, 40) == 0), ($urandom_range(0, 7) == 0),
                 6'($urandom), 16'($urandom));
        end
        repeat (4) step(1'b0, 1'b0, 16'h0, 1'b0);
        chk("queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/window_feed.md
WINDOW_FEED -- requirements
Module: window_feed

Interface
REQ-001 SHALL have parameter WIDTH, default 16, sample and coefficient width in bits (signed, Q1.15 at default).
REQ-002 SHALL have parameter LOG_N, default 6, log2 of frame length N = 2^LOG_N.
REQ-003 SHALL have port clock  in  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  in  1  stream enable; frames start only while high.
REQ-006 SHALL have port di_en  in  1  input sample valid.
REQ-007 SHALL have port di_re  in  WIDTH  input sample, signed.
REQ-008 SHALL have port restart  in  1  forces the next accepted sample to index 0.
REQ-009 SHALL have ports coef_we  in  1, coef_addr  in  LOG_N, coef_data  in  WIDTH  coefficient write port (see REQ-027).
REQ-010 SHALL have ports a_re  out  WIDTH  and b_re  out  WIDTH: the registered sample and its window coefficient, wired to the real multiplier inputs.
REQ-011 SHALL have ports do_en  out  1, do_first  out  1, do_last  out  1: pair valid, index-0 marker and index-(N-1) marker.
REQ-012 SHALL have port frame_cnt  out  16  count of completed frames.

Function
REQ-013 SHALL use states IDLE, RUN, DRAIN, a LOG_N-bit index counter and an N x WIDTH coefficient memory.
REQ-014 IDLE: samples dropped and index held at 0; transitions to RUN on the edge where enable=1.
REQ-015 RUN: each di_en=1 cycle accepts di_re at the current index, then increments the index, wrapping from N-1 to 0.
REQ-016 RUN with enable=0: goes to IDLE if the index is 0, otherwise to DRAIN.
REQ-017 DRAIN: keeps accepting samples until the sample at index N-1 is accepted, then goes to IDLE; enable re-asserted in DRAIN returns to RUN without breaking the frame.
REQ-018 di_en=0: index, state outputs and frame_cnt hold; gaps of any length are legal.
REQ-019 Latency: an accepted sample appears on a_re with do_en=1 exactly 2 cycles later; b_re is mem[index] at acceptance; pairs are never reordered or dropped in RUN/DRAIN.
REQ-020 do_first=1 only with do_en=1 at index 0; do_last=1 only with do_en=1 at index N-1.
REQ-021 restart=1 with di_en=1 in RUN/DRAIN: that sample takes index 0; restart=1 with di_en=0: the index clears to 0 and the next sample takes index 0; a partial frame aborted this way does not increment frame_cnt.
REQ-022 frame_cnt increments on acceptance of each index N-1 sample and wraps 0xFFFF->0.
REQ-023 When do_en=0, a_re and b_re hold their last values.
REQ-024 No arithmetic is performed; data paths pass unmodified, sign-preserved.

Reset
REQ-025 While reset_n=0: state=IDLE, index=0, a_re=0, b_re=0, do_en=0, do_first=0, do_last=0, frame_cnt=0, pipeline valids cleared; samples in flight are discarded.
REQ-026 Reset SHALL NOT clear coefficient memory; after reset release, the first edge with enable=1 enters RUN.

Configuration
REQ-027 With macro WINDOW_FEED_COEF_WR_EN defined: coef_we=1 writes coef_data to mem[coef_addr] on the edge; a same-cycle read of the same address returns the old value.
REQ-028 Without WINDOW_FEED_COEF_WR_EN: the coef_* ports exist but are ignored, no memory is built, and b_re = 2^(WIDTH-1)-1 (0x7FFF) for every pair (rectangular window).

Verification
REQ-029 Macro on: write mem[k]=k+0x100 for all k, enable=1, 64 consecutive samples 0..63 -> 64 pairs at latency 2 with a_re=k and b_re=k+0x100; do_first on pair 0, do_last on pair 63; frame_cnt=1.
REQ-030 Insert random di_en gaps in the REQ-029 stream -> identical pair sequence, each pair exactly 2 cycles after its input, frame_cnt=1.
REQ-031 Drop enable after 10 samples of a frame -> DRAIN, remaining 54 samples still emitted, then IDLE; further samples produce no do_en.
REQ-032 Assert restart together with sample 20 -> that pair has do_first=1 and b_re=mem[0]; frame_cnt unchanged until the next index-63 sample.
REQ-033 Pulse reset_n low mid-frame with two pairs in flight -> outputs zero immediately, no do_en after release until a new sample is accepted in RUN; coefficients retained.
REQ-034 Macro off: any stream -> b_re=0x7FFF on every pair; coef_we pulses have no effect.
